// File: rtl/cini_pkg.sv
// Shared types and helpers for the CINI HPC2 output voting slice.
//   K       masking order of the upstream gadget (d=1, k=1)
//   NCOPY   redundant copies per share (2K+1)
//   NSHARE  output shares produced by the gadget
//   vote_beat_t  one voted output beat {s0, s1, fault}
//   maj3    2-of-3 majority vote
//   agree3  all three copies identical
package cini_pkg;

   localparam int K      = 1;
   localparam int NCOPY  = 2 * K + 1;
   localparam int NSHARE = 2;

   typedef struct packed {
      logic s0;
      logic s1;
      logic fault;
   } vote_beat_t;

   function automatic logic maj3(input logic [NCOPY-1:0] c);
      return (c[0] & c[1]) | (c[0] & c[2]) | (c[1] & c[2]);
   endfunction

   function automatic logic agree3(input logic [NCOPY-1:0] c);
      return (c == '0) || (c == '1);
   endfunction

endpackage

// File: rtl/cini_vote_fifo.sv
// Synchronous FIFO of voted beats.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   push         write push_beat (dropped when full unless popping too)
//   push_beat    beat to store
//   pop          remove the head entry (ignored when empty)
//   head         head entry, zero while empty
//   count        registered occupancy
//   empty, full  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module cini_vote_fifo
   import cini_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  vote_beat_t                 push_beat,
   input  logic                       pop,
   output vote_beat_t                 head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   vote_beat_t        mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_en;
   logic              rd_en;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A pop frees the head slot in the same edge, so full+push+pop is legal.
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;

   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_beat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cini_out_vote.sv
// Output stage of the d=1, k=1 CINI HPC2 AND gadget.
// Tracks the gadget's fixed latency with a valid shift register, majority
// votes each triplicated share on its own (shares are never combined), flags
// copy disagreement, and buffers beats in a FIFO with valid/ready. Issue is
// throttled by credits so the non-stallable gadget can never overflow it.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   issue             new operation's b-shares enter the gadget
//   issue_ready       credit available, issue is accepted this cycle
//   io_c_0, io_c_1    triplicated output shares from the gadget
//   out_valid/ready   consumer handshake
//   out_s0, out_s1    voted shares of the head beat
//   out_fault         head beat had a copy mismatch
//   fault_sticky      any mismatch since reset / fault_clr
//   fault_clr         synchronous clear of fault_sticky and fault_cnt
//   fault_cnt         saturating count of faulty beats
// Build option: define CINI_FAULT_CNT_EN to include the fault counter;
// otherwise fault_cnt is tied to zero.
module cini_out_vote
   import cini_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue,
   output logic              issue_ready,
   input  logic [NCOPY-1:0]  io_c_0,
   input  logic [NCOPY-1:0]  io_c_1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_s0,
   output logic              out_s1,
   output logic              out_fault,
   output logic              fault_sticky,
   input  logic              fault_clr,
   output logic [CNT_W-1:0]  fault_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [LAT-1:0]  vp;
   logic            sample;
   logic [CW:0]     credit_use;
   logic [CW-1:0]   occ;
   logic            fifo_empty;
   logic            fifo_full;
   logic            pop;
   logic            overflow;
   vote_beat_t      beat;
   vote_beat_t      head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vp <= '0;
      end else begin
         vp[0] <= issue & issue_ready;
         for (int i = 1; i < LAT; i++) vp[i] <= vp[i-1];
      end
   end

   assign sample = vp[LAT-1];

   // Credits cover buffered beats plus every operation still inside the
   // gadget; occupancy is registered, so a pop frees a credit one cycle late.
   always_comb begin
      credit_use = {1'b0, occ};
      for (int i = 0; i < LAT; i++) credit_use = credit_use + (CW+1)'(vp[i]);
   end

   assign issue_ready = credit_use < (CW+1)'(DEPTH);

   always_comb begin
      beat       = '0;
      beat.s0    = maj3(io_c_0);
      beat.s1    = maj3(io_c_1);
      beat.fault = ~agree3(io_c_0) | ~agree3(io_c_1);
   end

   assign pop      = out_valid & out_ready;
   assign overflow = sample & fifo_full & ~pop;

   cini_vote_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (sample),
      .push_beat (beat),
      .pop       (pop),
      .head      (head),
      .count     (occ),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign out_valid = ~fifo_empty;
   assign out_s0    = head.s0;
   assign out_s1    = head.s1;
   assign out_fault = head.fault;

   // A dropped beat is itself a fault; set has priority over clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_sticky <= 1'b0;
      end else if ((sample & beat.fault) | overflow) begin
         fault_sticky <= 1'b1;
      end else if (fault_clr) begin
         fault_sticky <= 1'b0;
      end
   end

`ifdef CINI_FAULT_CNT_EN
   logic cnt_inc;

   assign cnt_inc = sample & beat.fault;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_cnt <= '0;
      end else if (fault_clr) begin
         fault_cnt <= cnt_inc ? CNT_W'(1) : '0;
      end else if (cnt_inc && (fault_cnt != '1)) begin
         fault_cnt <= fault_cnt + CNT_W'(1);
      end
   end
`else
   assign fault_cnt = '0;
`endif

   ovf_never: assert property (@(posedge clk) disable iff (!reset) !overflow);

endmodule

// File: doc/cini_out_vote.md
Name: cini_out_vote

Overview:
- Downstream stage of the d=1, k=1 CINI HPC2 AND gadget.
- Consumes the two triplicated output shares (c_0, c_1; 3 copies each) and tracks the gadget's fixed 2-cycle latency with a valid shift register.
- Majority-votes each share independently (shares are never combined) and flags copy disagreement as a detected fault.
- Buffers voted beats in a small FIFO with valid/ready to the consumer; credit logic throttles issue so the non-stallable gadget never overflows.

Parameters:
- LAT, 2, gadget latency in cycles from b-issue to valid io_c_*.
- DEPTH, 4, output FIFO entries; must be >= LAT+1.
- CNT_W, 8, width of the fault counter (saturating).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- issue  in  1  pulse when io_b_* of a new operation enters the gadget; a_* follows one cycle later.
- issue_ready  out  1  issuing is allowed this cycle (credit available).
- io_c_0  in  3  triplicated share 0 from the gadget.
- io_c_1  in  3  triplicated share 1 from the gadget.
- out_valid  out  1  voted beat available.
- out_ready  in  1  consumer accepts the beat.
- out_s0  out  1  voted share 0.
- out_s1  out  1  voted share 1.
- out_fault  out  1  the beat at head had a copy mismatch in either share.
- fault_sticky  out  1  any mismatch since reset/clear.
- fault_clr  in  1  synchronous clear of fault_sticky and fault_cnt.
- fault_cnt  out  CNT_W  count of faulty beats (only with CINI_FAULT_CNT_EN).

Behaviour:
- Reset (reset=0, async): valid pipe=0, FIFO empty, out_valid=0, out_s0/out_s1/out_fault=0, fault_sticky=0, fault_cnt=0, issue_ready=1.
- Valid pipe: vp[0] <= issue & issue_ready; vp[i] <= vp[i-1]. Sample io_c_* when vp[LAT-1]=1, i.e. exactly LAT cycles after issue.
- issue while issue_ready=0 is ignored: not tracked, and no sample is taken.
- Vote per share: s = maj(c[0],c[1],c[2]). fault = ~(c[0]==c[1]==c[2]) for c_0 OR c_1.
- Each sample writes {s0,s1,fault} into the FIFO in the sample cycle. The entry is visible on out_* the next cycle; sample-to-out_valid latency is 1 cycle.
- Pop on out_valid & out_ready. out_* holds stable while out_valid & ~out_ready.
- Credits: inflight = popcount(vp). issue_ready = (occupancy + inflight) < DEPTH.
  - A pop in the same cycle does not free a credit until the next cycle (registered occupancy).
- Full FIFO plus a push is unreachable by construction. An assertion fires on it; the beat is dropped and fault_sticky is set.
- Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.
- Simultaneous push and pop on an empty FIFO: push is stored, out_valid rises next cycle (no bypass).
- fault_sticky is set on the sample of a faulty beat. If fault_clr and a faulty sample occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH; DEPTH must be a power of two.
- Reset mid-operation discards all in-flight and buffered beats.

Optional Feature:
- CINI_FAULT_CNT_EN.
- Defined: fault_cnt increments by 1 per faulty sample and saturates at 2^CNT_W-1. fault_clr zeroes it; clear and increment in the same cycle gives 1.
- Undefined: no counter register; fault_cnt is tied to 0.

Decomposition:
- Package cini_pkg: constants K=1, NCOPY=2K+1=3, NSHARE=2; typedef vote_beat_t {s0,s1,fault}; function maj3.
- One sub-module: cini_vote_fifo (synchronous FIFO of vote_beat_t, DEPTH entries, count output).

Test Plan:
- Single issue at t0, io_c_0=3'b111 and io_c_1=3'b000 at t0+2, out_ready=1 -> out_valid at t0+3, s0=1, s1=0, fault=0.
- io_c_0=3'b101 at sample -> s0=1, out_fault=1, fault_sticky=1, fault_cnt=1 (with macro); macro off -> fault_cnt=0.
- out_ready=0, issue every cycle -> issue_ready drops after DEPTH=4 issues; exactly 4 beats buffered in order, no overflow assertion.
- Back-to-back issues with out_ready=1 -> one beat per cycle, continuous out_valid, values track the copies sampled 2 cycles after each issue.
- Hold fault_clr with a faulty sample in the same cycle -> fault_sticky=1 and fault_cnt=1. Assert reset with 2 beats in flight -> all outputs 0, nothing emitted afterwards.
- Feed 300 faulty beats with CNT_W=8 -> fault_cnt saturates at 255.
